// File: rtl/spi_master_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : spi_master_if                                         |
// | Purpose  : Host-side command/response bundle for spi_master.     |
// |            The host drives commands through the master modport;  |
// |            the SPI engine sits on the slave modport.             |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
interface spi_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : spi_master                                            |
// | Purpose  : Mode-0 SPI master. Each command sends {op[1], op,     |
// |            data} MSB first; op 11 adds a dummy turnaround pulse  |
// |            and reads one byte from miso.                         |
// | Options  : SPI_MASTER_CMD_BUF_EN adds a one-entry command buffer |
// |            so a second command can be queued during a frame.    |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module spi_master #(
  parameter int CLK_DIV = 4   // clk cycles per SCLK half-period, 1..255
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  spi_master_if.slave host,
  output logic        sclk,
  output logic        ss_n,
  output logic        mosi,
  input  wire logic   miso
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TURN  = 3'd3,
    ST_READ  = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  localparam logic [7:0] c_div_last       = 8'(CLK_DIV - 1);
  localparam logic [4:0] c_last_shift_bit = 5'd10;
  localparam logic [4:0] c_last_read_bit  = 5'd19;

  state_t     state_q, state_d;
  logic [7:0] div_cnt_q, div_cnt_d;
  logic       half_q, half_d;        // 0: sclk-high half (or first STOP half), 1: second half
  logic [4:0] bit_cnt_q, bit_cnt_d;  // completed SCLK pulses in this frame
  logic [9:0] shreg_q, shreg_d;      // {op, data}, shifted out MSB first
  logic       is_read_q, is_read_d;
  logic [7:0] rx_q, rx_d;            // miso accumulator during READ
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       sclk_q, sclk_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;

  logic       w_div_last;
  logic       w_cmd_fire;
  logic       w_start;
  logic [1:0] w_start_op;
  logic [7:0] w_start_data;

  assign w_div_last = (div_cnt_q == c_div_last);

`ifdef SPI_MASTER_CMD_BUF_EN
  logic       buf_valid_q, buf_valid_d;
  logic [1:0] buf_op_q, buf_op_d;
  logic [7:0] buf_data_q, buf_data_d;
  logic       w_launch_window;

  // A frame may launch from IDLE or straight out of the last STOP cycle,
  // which keeps the ss_n high gap between queued frames at exactly 2*CLK_DIV.
  assign w_launch_window = (state_q == ST_IDLE) ||
                           ((state_q == ST_STOP) && half_q && w_div_last);
  assign host.cmd_ready  = ~buf_valid_q;
  assign w_cmd_fire      = host.cmd_valid & ~buf_valid_q;
  assign w_start         = w_launch_window & (buf_valid_q | w_cmd_fire);
  assign w_start_op      = buf_valid_q ? buf_op_q   : host.cmd_op;
  assign w_start_data    = buf_valid_q ? buf_data_q : host.cmd_data;

  // Buffer fills when a command arrives outside a launch window, drains on launch.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_op_d    = buf_op_q;
    buf_data_d  = buf_data_q;
    if (w_start && buf_valid_q) begin
      buf_valid_d = 1'b0;
    end
    if (w_cmd_fire && !w_launch_window) begin
      buf_valid_d = 1'b1;
      buf_op_d    = host.cmd_op;
      buf_data_d  = host.cmd_data;
    end
  end

  // Command buffer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_op_q    <= 2'b00;
      buf_data_q  <= 8'h00;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_op_q    <= buf_op_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign host.cmd_ready = (state_q == ST_IDLE);
  assign w_cmd_fire     = host.cmd_valid & (state_q == ST_IDLE);
  assign w_start        = w_cmd_fire;
  assign w_start_op     = host.cmd_op;
  assign w_start_data   = host.cmd_data;
`endif

  // Frame sequencing: next state, counters, shift registers and pin values.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = w_div_last ? 8'd0 : div_cnt_q + 8'd1;
    half_d      = half_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    is_read_d   = is_read_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    mosi_d      = mosi_q;

    case (state_q)
      ST_IDLE: begin
        div_cnt_d = 8'd0;
        mosi_d    = 1'b0;
      end
      ST_START: begin
        if (w_div_last) begin
          state_d = ST_SHIFT;
          half_d  = 1'b0;
        end
      end
      ST_SHIFT, ST_TURN, ST_READ: begin
        // Sample miso in the first cycle of each READ sclk-high phase.
        if ((state_q == ST_READ) && !half_q && (div_cnt_q == 8'd0)) begin
          rx_d = {rx_q[6:0], miso};
        end
        if (w_div_last) begin
          if (!half_q) begin
            // sclk falls: the only moment mosi may move.
            half_d = 1'b1;
            if (state_q == ST_SHIFT) begin
              if (bit_cnt_q == c_last_shift_bit) begin
                mosi_d = 1'b0;
              end else begin
                mosi_d  = shreg_q[9];
                shreg_d = {shreg_q[8:0], 1'b0};
              end
            end
          end else begin
            half_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (state_q == ST_SHIFT) begin
              if (bit_cnt_q == c_last_shift_bit) begin
                state_d = is_read_q ? ST_TURN : ST_STOP;
              end
            end else if (state_q == ST_TURN) begin
              state_d = ST_READ;
            end else if (bit_cnt_q == c_last_read_bit) begin
              state_d     = ST_STOP;
              rsp_valid_d = 1'b1;
              rsp_data_d  = rx_q;
            end
          end
        end
      end
      ST_STOP: begin
        mosi_d = 1'b0;
        if (w_div_last) begin
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d    = 1'b0;
            bit_cnt_d = 5'd0;
            state_d   = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_start) begin
      state_d   = ST_START;
      div_cnt_d = 8'd0;
      half_d    = 1'b0;
      bit_cnt_d = 5'd0;
      shreg_d   = {w_start_op, w_start_data};
      is_read_d = (w_start_op == 2'b11);
      mosi_d    = w_start_op[1];
    end
  end

  // Pin levels are derived from the next state so the pins are plain flops.
  always_comb begin
    sclk_d = (state_d inside {ST_SHIFT, ST_TURN, ST_READ}) && !half_d;
    ss_n_d = !(state_d inside {ST_START, ST_SHIFT, ST_TURN, ST_READ});
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= 8'd0;
      half_q      <= 1'b0;
      bit_cnt_q   <= 5'd0;
      shreg_q     <= 10'd0;
      is_read_q   <= 1'b0;
      rx_q        <= 8'h00;
      rsp_data_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      sclk_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      half_q      <= half_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      is_read_q   <= is_read_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      sclk_q      <= sclk_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
    end
  end

  assign sclk          = sclk_q;
  assign ss_n          = ss_n_q;
  assign mosi          = mosi_q;
  assign host.busy     = (state_q != ST_IDLE);
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_spi_master                                         |
// | Purpose  : Directed bench for spi_master (CLK_DIV=2) with a      |
// |            per-cycle waveform model and a mode-0 miso slave.     |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_spi_master;
  localparam int D = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic miso  = 1'b0;
  logic sclk, ss_n, mosi;

  spi_master_if bus();

  spi_master #(.CLK_DIV(D)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .host (bus),
    .sclk (sclk),
    .ss_n (ss_n),
    .mosi (mosi),
    .miso (miso)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // One expected cycle of pin activity while a frame (START..STOP) is active.
  typedef struct packed {
    logic       ss_n;
    logic       sclk;
    logic       mosi;
    logic       rsp_valid;
    logic       upd;
    logic [7:0] rsp;
  } ent_t;

  ent_t       exp_q[$];
  logic [7:0] miso_byte = 8'h00;
  logic [7:0] exp_rsp   = 8'h00;
  int         buf_left  = 0;
  logic       armed     = 1'b0;

  // waveform measurements
  int          low_len = 0, last_low = 0, high_len = 0, last_gap = 0;
  int          pulses = 0, rsp_pulses = 0;
  logic [10:0] cap = '0;
  logic        prev_ss_n = 1'b1, prev_sclk = 1'b0;

  // Expected frame: START (D), N pulses of D high / D low, STOP (2D).
  task automatic push_frame(input logic [1:0] op, input logic [7:0] d);
    logic [10:0] bits;
    int          npulse;
    ent_t        e;
    bits   = {op[1], op, d};
    npulse = (op == 2'b11) ? 20 : 11;
    for (int i = 0; i < D; i++) begin
      e = {1'b0, 1'b0, bits[10], 1'b0, 1'b0, 8'h00};
      exp_q.push_back(e);
    end
    for (int p = 0; p < npulse; p++) begin
      for (int i = 0; i < D; i++) begin
        e = {1'b0, 1'b1, (p < 11) ? bits[10 - p] : 1'b0, 1'b0, 1'b0, 8'h00};
        exp_q.push_back(e);
      end
      for (int i = 0; i < D; i++) begin
        e = {1'b0, 1'b0, (p + 1 < 11) ? bits[9 - p] : 1'b0, 1'b0, 1'b0, 8'h00};
        exp_q.push_back(e);
      end
    end
    for (int i = 0; i < 2 * D; i++) begin
      e = {1'b1, 1'b0, 1'b0, (op == 2'b11) && (i == 0), (op == 2'b11) && (i == 0), miso_byte};
      exp_q.push_back(e);
    end
  endtask

  // Cycle-by-cycle compare against the model, plus waveform measurements.
  always @(negedge clk) begin : compare
    ent_t        e;
    logic        idle, want_ready;
    logic [13:0] got, want;
    if (armed) begin
      idle = (exp_q.size() == 0);
      if (idle) e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      else      e = exp_q.pop_front();
      if (e.upd) exp_rsp = e.rsp;
`ifdef SPI_MASTER_CMD_BUF_EN
      want_ready = (buf_left == 0);
`else
      want_ready = idle;
`endif
      want = {e.ss_n, e.sclk, e.mosi, e.rsp_valid, !idle, want_ready, exp_rsp};
      got  = {ss_n, sclk, mosi, bus.rsp_valid, bus.busy, bus.cmd_ready, bus.rsp_data};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL cycle_model t=%0t ss_n/sclk/mosi/rv/busy/rdy/rsp got %b required %b",
                 $time, got, want);
      end
      if (buf_left > 0) buf_left--;
    end

    if (ss_n === 1'b0) begin
      if (prev_ss_n) begin
        last_gap = high_len; low_len = 0; pulses = 0; cap = '0; rsp_pulses = 0;
      end
      low_len++;
      if (sclk && !prev_sclk) begin
        pulses++;
        cap = {cap[9:0], mosi};
      end
    end else begin
      if (!prev_ss_n) begin
        last_low = low_len; high_len = 0;
      end
      high_len++;
    end
    if (bus.rsp_valid === 1'b1) rsp_pulses++;
    prev_ss_n = (ss_n !== 1'b0);
    prev_sclk = (sclk === 1'b1);

    if (!rst_n) begin
      armed = 1'b1; exp_q.delete(); exp_rsp = 8'h00; buf_left = 0;
    end else if (armed && bus.cmd_valid && bus.cmd_ready) begin
`ifdef SPI_MASTER_CMD_BUF_EN
      if (exp_q.size() != 0) buf_left = exp_q.size();
`endif
      push_frame(bus.cmd_op, bus.cmd_data);
    end
  end

  // Mode-0 slave: present miso_byte MSB first, changing after each sclk fall
  // that follows the dummy turnaround pulse.
  always @(negedge clk) begin : slave
    int   falls;
    logic ps;
    if (ss_n !== 1'b0) begin
      falls = 0; miso = 1'b0;
    end else if (ps && (sclk === 1'b0)) begin
      falls++;
      if (falls >= 12 && falls <= 19) miso = miso_byte[19 - falls];
      else                            miso = 1'b0;
    end
    ps = (sclk === 1'b1);
  end

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d required %0d", name, got, want);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 500) begin @(negedge clk); n++; end
    if (!bus.cmd_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] d);
    bus.cmd_op = op; bus.cmd_data = d; bus.cmd_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Wait for ss_n to rise, then count cycles until cmd_ready returns.
  task automatic finish_frame(output int gap);
    int n = 0;
    gap = 0;
    @(negedge clk);
    while (ss_n !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    if (ss_n !== 1'b1) check("frame_timeout", 0, 1);
    n = 0;
    while (!bus.cmd_ready && n < 100) begin @(negedge clk); gap++; n++; end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 500) begin @(negedge clk); n++; end
    if (bus.busy) check("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin : stim
    int gap;
    int n;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_data = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_ss_n", ss_n, 1);
    check("reset_sclk", sclk, 0);
    check("reset_ready", bus.cmd_ready, 1);
    check("reset_rsp_data", bus.rsp_data, 0);
    @(posedge clk); #1;

    // write address 0x3C
    send(2'b00, 8'h3C); finish_frame(gap);
    check("wa_low_len", last_low, 46);
    check("wa_mosi_bits", cap, 11'b00000111100);
    check("wa_pulses", pulses, 11);
    check("wa_no_rsp", rsp_pulses, 0);
    check("wa_ready_gap", gap, 4);

    // write data 0xA5
    send(2'b01, 8'hA5); finish_frame(gap);
    check("wd_mosi_bits", cap, 11'b00110100101);
    check("wd_pulses", pulses, 11);
    check("wd_low_len", last_low, 46);

    // read address 0x5A
    send(2'b10, 8'h5A); finish_frame(gap);
    check("ra_mosi_bits", cap, 11'b11001011010);
    check("ra_no_rsp", rsp_pulses, 0);

    // read data, slave returns 0x96
    miso_byte = 8'h96;
    send(2'b11, 8'h00); finish_frame(gap);
    check("rd_low_len", last_low, 82);
    check("rd_pulses", pulses, 20);
    check("rd_rsp_pulses", rsp_pulses, 1);
    check("rd_rsp_data", bus.rsp_data, 8'h96);

    // reset during the 6th sclk pulse of a read
    miso_byte = 8'h3C;
    send(2'b11, 8'hFF);
    n = 0;
    while (pulses < 6 && n < 500) begin @(negedge clk); n++; end
    if (pulses < 6) check("pulse6_timeout", pulses, 6);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_ss_n", ss_n, 1);
    check("abort_sclk", sclk, 0);
    check("abort_rsp_data", bus.rsp_data, 0);
    repeat (20) @(negedge clk);
    check("abort_no_rsp", rsp_pulses, 0);
    @(posedge clk); #1;

    send(2'b01, 8'hC3); finish_frame(gap);
    check("post_abort_low_len", last_low, 46);
    check("post_abort_bits", cap, 11'b00111000011);

    miso_byte = 8'h5A;
    send(2'b11, 8'h12); finish_frame(gap);
    check("rd2_rsp_data", bus.rsp_data, 8'h5A);

    // back-to-back: cmd_valid held across two commands
    bus.cmd_op = 2'b10; bus.cmd_data = 8'h11; bus.cmd_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    bus.cmd_op = 2'b00; bus.cmd_data = 8'h77;
    wait_ready();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    finish_frame(gap);
`ifdef SPI_MASTER_CMD_BUF_EN
    check("b2b_ss_n_gap", last_gap, 4);
`else
    check("b2b_ss_n_gap", last_gap, 5);
`endif
    wait_idle();
    check("b2b_low_len", last_low, 46);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    miscompares++;
    $display("FAIL global_timeout got running required finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
